// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencer: state encoding, widths and
// the counter-pin pattern that belongs to each state.
package counter_seq_ctrl_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int STATE_W       = 3;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_LOAD   = 3'd1;
    localparam logic [STATE_W-1:0] S_SETTLE = 3'd2;
    localparam logic [STATE_W-1:0] S_COUNT  = 3'd3;
    localparam logic [STATE_W-1:0] S_READ   = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE   = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = S_IDLE,
        ST_LOAD   = S_LOAD,
        ST_SETTLE = S_SETTLE,
        ST_COUNT  = S_COUNT,
        ST_READ   = S_READ,
        ST_DONE   = S_DONE
    } state_t;

    // {load, en, oe} driven while in a state; at most one bit is ever set.
    function automatic logic [2:0] ctrl_pins(input state_t s);
        logic [2:0] pins;
        pins = 3'b000;
        case (s)
            ST_LOAD:  pins = 3'b100;
            ST_COUNT: pins = 3'b010;
            ST_READ:  pins = 3'b001;
            default:  pins = 3'b000;
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/counter_seq_ctrl_timer.sv
// Loadable down-counter with zero/one flags; paces both the COUNT and READ dwell.
module seq_down_timer
    import counter_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             is_zero,
    output logic             is_one
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !is_zero) begin
            count <= count - 1'b1;
        end
    end

    assign is_zero = (count == '0);
    assign is_one  = (count == WIDTH'(1));

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for a prog_counter8-style counter: load, step, read back over the
// shared bus and compare against cmd_val + cmd_steps.
//
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | cnt_load high for one cycle with the latched start value
//   SETTLE | all counter pins low for one cycle
//   COUNT  | cnt_en high for exactly cmd_steps cycles
//   READ   | cnt_oe high for OE_SETTLE+1 cycles, bus sampled on the last edge
//   DONE   | done pulse, rd_data/err valid
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int OE_SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] cmd_val,
    input  logic [WIDTH-1:0] cmd_steps,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rd_data,
    output logic             err,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             cnt_en,
    output logic             cnt_oe,
    input  logic [WIDTH-1:0] bus_in
);

    localparam logic [WIDTH-1:0] READ_CYCLES = WIDTH'(OE_SETTLE + 1);

    state_t           state;
    logic [WIDTH-1:0] steps_q;
    logic [WIDTH-1:0] exp_q;

    logic             tmr_load;
    logic             tmr_dec;
    logic [WIDTH-1:0] tmr_val;
    logic             tmr_zero;
    logic             tmr_one;
    logic             tmr_last;

    // The timer is armed in the cycle before a dwell begins, so it already
    // holds the dwell length on the first cycle of COUNT/READ.
    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_SETTLE: begin
                tmr_load = 1'b1;
                tmr_val  = (steps_q != '0) ? steps_q : READ_CYCLES;
            end
            ST_COUNT: begin
                if (tmr_last) begin
                    tmr_load = 1'b1;
                    tmr_val  = READ_CYCLES;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_READ: tmr_dec = 1'b1;
            default: ;
        endcase
    end

    assign tmr_last = tmr_one || tmr_zero;

    seq_down_timer #(
        .WIDTH (WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .is_zero  (tmr_zero),
        .is_one   (tmr_one)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                      <= ST_IDLE;
            steps_q                    <= '0;
            exp_q                      <= '0;
            busy                       <= 1'b0;
            done                       <= 1'b0;
            rd_data                    <= '0;
            err                        <= 1'b0;
            cnt_load_val               <= '0;
            {cnt_load, cnt_en, cnt_oe} <= 3'b000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        steps_q                    <= cmd_steps;
                        exp_q                      <= cmd_val + cmd_steps;
                        cnt_load_val               <= cmd_val;
                        busy                       <= 1'b1;
                        {cnt_load, cnt_en, cnt_oe} <= ctrl_pins(ST_LOAD);
                        state                      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    {cnt_load, cnt_en, cnt_oe} <= ctrl_pins(ST_SETTLE);
                    state                      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (steps_q != '0) begin
                        {cnt_load, cnt_en, cnt_oe} <= ctrl_pins(ST_COUNT);
                        state                      <= ST_COUNT;
                    end else begin
                        {cnt_load, cnt_en, cnt_oe} <= ctrl_pins(ST_READ);
                        state                      <= ST_READ;
                    end
                end
                ST_COUNT: begin
                    if (tmr_last) begin
                        {cnt_load, cnt_en, cnt_oe} <= ctrl_pins(ST_READ);
                        state                      <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (tmr_last) begin
                        rd_data                    <= bus_in;
                        err                        <= (bus_in != exp_q);
                        done                       <= 1'b1;
                        {cnt_load, cnt_en, cnt_oe} <= ctrl_pins(ST_DONE);
                        state                      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done                       <= 1'b0;
                    busy                       <= 1'b0;
                    {cnt_load, cnt_en, cnt_oe} <= 3'b000;
                    state                      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl with a behavioural prog_counter8 on the counter pins
// and a scoreboard of expected results checked on every done pulse.
module tb_counter_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] cmd_val;
    logic [7:0] cmd_steps;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       err;
    logic       cnt_load;
    logic [7:0] cnt_load_val;
    logic       cnt_en;
    logic       cnt_oe;
    logic [7:0] bus_in;

    logic [7:0] cnt_q;
    logic       force_zero;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
        int         steps;
        int         e0;
    } sb_t;

    sb_t sb[$];

    typedef struct {
        logic [7:0] val;
        logic [7:0] steps;
        logic       force0;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    counter_seq_ctrl #(
        .WIDTH     (8),
        .OE_SETTLE (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cmd_val      (cmd_val),
        .cmd_steps    (cmd_steps),
        .busy         (busy),
        .done         (done),
        .rd_data      (rd_data),
        .err          (err),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .cnt_en       (cnt_en),
        .cnt_oe       (cnt_oe),
        .bus_in       (bus_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural prog_counter8; an undriven bus reads as EE.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt_q <= 8'h00;
        else if (cnt_load) cnt_q <= cnt_load_val;
        else if (cnt_en)   cnt_q <= cnt_q + 8'h01;
    end

    assign bus_in = cnt_oe ? (force_zero ? 8'h00 : cnt_q) : 8'hEE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pin exclusivity every cycle, scoreboard pop on done.
    int en_cnt = 0;
    int ld_cnt = 0;
    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            en_cnt = 0;
            ld_cnt = 0;
        end else begin
            check("pins_exclusive", 32'(cnt_load) + 32'(cnt_en) + 32'(cnt_oe) <= 1, 1);
            if (cnt_en)   en_cnt++;
            if (cnt_load) ld_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rd_data", rd_data, e.data);
                    check("err", err, e.err);
                    check("latency", cyc - e.e0, e.lat);
                    check("en_cycles", en_cnt, e.steps);
                    check("load_cycles", ld_cnt, 1);
                    check("busy_at_done", busy, 1);
                end
                en_cnt = 0;
                ld_cnt = 0;
            end
        end
    end

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        cmd_val    = v.val;
        cmd_steps  = v.steps;
        force_zero = v.force0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back('{v.exp_data, v.exp_err, v.exp_lat, int'(v.steps), cyc});
        wait_idle("vec_idle_timeout");
        force_zero = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, done, rd_data, err, cnt_load, cnt_load_val, cnt_en, cnt_oe}, 0);
    endtask

    vec_t vecs[7];

    initial begin
        int drops;
        vecs[0] = '{8'hA5, 8'd3,   1'b0, 8'hA8, 1'b0, 7};
        vecs[1] = '{8'hFF, 8'd2,   1'b0, 8'h01, 1'b0, 6};
        vecs[2] = '{8'h3C, 8'd0,   1'b0, 8'h3C, 1'b0, 4};
        vecs[3] = '{8'h10, 8'd1,   1'b1, 8'h00, 1'b1, 5};
        vecs[4] = '{8'h7F, 8'd1,   1'b0, 8'h80, 1'b0, 5};
        vecs[5] = '{8'h00, 8'd255, 1'b0, 8'hFF, 1'b0, 259};
        vecs[6] = '{8'hC8, 8'd64,  1'b0, 8'h08, 1'b0, 68};

        rst_n      = 1'b0;
        start      = 1'b0;
        cmd_val    = 8'h00;
        cmd_steps  = 8'h00;
        force_zero = 1'b0;
        start      = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_outputs");
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset_idle");

        foreach (vecs[i]) run_vec(vecs[i]);
        check("load_val_held", cnt_load_val, 8'hC8);

        // start re-pulsed during COUNT must be ignored
        @(negedge clk);
        cmd_val   = 8'h11;
        cmd_steps = 8'd4;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back('{8'h15, 1'b0, 8, 4, cyc});
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) begin
                cmd_val   = 8'h99;
                cmd_steps = 8'd2;
                start     = 1'b1;
            end
            if (i == 3) start = 1'b0;
            if (!busy) drops++;
            if (done) break;
        end
        check("busy_continuous", drops, 0);
        wait_idle("ignored_idle_timeout");
        repeat (3) @(negedge clk);
        check("ignored_not_queued", busy, 0);
        check("ignored_load_val", cnt_load_val, 8'h11);

        // reset mid-COUNT aborts
        @(negedge clk);
        cmd_val   = 8'h20;
        cmd_steps = 8'd8;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("in_count_before_reset", cnt_en, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_count");
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_abort", {busy, done, rd_data}, 0);
        run_vec('{8'h20, 8'd4, 1'b0, 8'h24, 1'b0, 8});

        // start held high across DONE: one idle cycle between commands
        @(negedge clk);
        cmd_val   = 8'h01;
        cmd_steps = 8'd1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{8'h02, 1'b0, 5, 1, cyc});
        @(negedge clk);
        cmd_val   = 8'h02;
        cmd_steps = 8'd2;
        wait_done("first_done_timeout");
        @(negedge clk);
        check("gap_busy_low", busy, 0);
        @(negedge clk);
        check("reaccept_busy_high", busy, 1);
        sb.push_back('{8'h04, 1'b0, 6, 2, cyc});
        start = 1'b0;
        wait_idle("second_idle_timeout");
        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
